conv_window_sequencer: RTL and testbench

Parametrised control and address sequencer for K×K image convolution over an IMG_W×IMG_H frame. It accepts a keyboard command and loads one of three kernel banks from kernel ROM. It then walks every output pixel, issuing one pixel-memory address per kernel tap, with border taps flagged for zero substitution. Each output pixel ends with a MAC clear/accumulate/write sequence to the output framebuffer. It sits between the PS/2 key decoder and the convolution datapath (kernel register file, MAC, normaliser).

---
 rtl/conv_pkg.sv | 45 ++++
 rtl/conv_window_sequencer_if.sv | 39 +++
 rtl/conv_window_counter.sv | 90 +++++++++
 rtl/conv_window_sequencer.sv | 134 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, PS/2 make codes for the six recognised keys,
// kernel bank count and small key-decode helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KER,
        ST_CONV,
        ST_WRITE,
        ST_HOLD
    } state_t;

    // Keys 1/2/3 show the original image; keys Q/W/E select a kernel bank.
    localparam logic [7:0] KEY_ORIG_0 = 8'h16;
    localparam logic [7:0] KEY_ORIG_1 = 8'h1E;
    localparam logic [7:0] KEY_ORIG_2 = 8'h26;
    localparam logic [7:0] KEY_KER0   = 8'h15;
    localparam logic [7:0] KEY_KER1   = 8'h1D;
    localparam logic [7:0] KEY_KER2   = 8'h24;

    localparam int NUM_BANKS = 3;
    localparam int BANK_W    = $clog2(NUM_BANKS);

    function automatic logic key_is_orig(input logic [7:0] key);
        return (key == KEY_ORIG_0) || (key == KEY_ORIG_1) || (key == KEY_ORIG_2);
    endfunction

    function automatic logic key_is_ker(input logic [7:0] key);
        return (key == KEY_KER0) || (key == KEY_KER1) || (key == KEY_KER2);
    endfunction

    function automatic logic [BANK_W-1:0] key_bank(input logic [7:0] key);
        logic [BANK_W-1:0] b;
        case (key)
            KEY_KER1: b = BANK_W'(1);
            KEY_KER2: b = BANK_W'(2);
            default:  b = BANK_W'(0);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Command/kernel/pixel/output bus of the convolution window sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_valid/cmd_ready handshake; all other strobes are unthrottled.
// master: key decoder / controller side (drives abort and commands).
// slave:  sequencer side (drives cmd_ready and all memory/MAC strobes).
interface conv_window_sequencer_if #(
    parameter int PIX_AW = 12,
    parameter int KER_AW = 5
);
    logic              abort;
    logic              cmd_valid;
    logic [7:0]        cmd_key;
    logic              cmd_ready;
    logic [KER_AW-1:0] ker_addr;
    logic              ker_load;
    logic [5:0]        ker_idx;
    logic [PIX_AW-1:0] pix_addr;
    logic              tap_valid;
    logic              tap_oob;
    logic [5:0]        tap_idx;
    logic              mac_clr;
    logic              out_we;
    logic [PIX_AW-1:0] out_addr;
    logic              show_orig;
    logic              busy;
    logic              done;

    modport master (
        output abort, cmd_valid, cmd_key,
        input  cmd_ready, ker_addr, ker_load, ker_idx, pix_addr, tap_valid,
               tap_oob, tap_idx, mac_clr, out_we, out_addr, show_orig, busy, done
    );

    modport slave (
        input  abort, cmd_valid, cmd_key,
        output cmd_ready, ker_addr, ker_load, ker_idx, pix_addr, tap_valid,
               tap_oob, tap_idx, mac_clr, out_we, out_addr, show_orig, busy, done
    );
endinterface

// File: rtl/conv_window_counter.sv
// Output-pixel (r,c) and kernel-tap (dy,dx) counters with border detection.
// Latency: combinational from counter state; counters advance on the step inputs.
// Backpressure: none; steps only when told to by the sequencer FSM.
// Ports: rst/clr clear all counters; tap_step advances the tap (wraps after K*K-1);
// pix_step advances the raster position; outputs tap index, sample address,
// out-of-frame flag, raster address and last-tap / last-pixel flags.
module conv_window_counter #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int K      = 3,
    parameter int PIX_AW = $clog2(IMG_W*IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              tap_step,
    input  logic              pix_step,
    output logic [5:0]        tap_idx,
    output logic              tap_last,
    output logic              pix_last,
    output logic              tap_oob,
    output logic [PIX_AW-1:0] tap_addr,
    output logic [PIX_AW-1:0] pos_addr
);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    // Two extra bits: one for the sign, one so r+dy can exceed the frame.
    localparam int SW = PIX_AW + 2;
    localparam logic signed [SW-1:0] H_S    = SW'(IMG_H);
    localparam logic signed [SW-1:0] W_S    = SW'(IMG_W);
    localparam logic signed [SW-1:0] HALF_S = SW'(K/2);

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [KW-1:0] dy;
    logic [KW-1:0] dx;

    logic dx_last;
    logic dy_last;
    logic c_last;
    logic r_last;

    assign dx_last  = (dx == KW'(K-1));
    assign dy_last  = (dy == KW'(K-1));
    assign c_last   = (c == CW'(IMG_W-1));
    assign r_last   = (r == RW'(IMG_H-1));
    assign tap_last = dx_last && dy_last;
    assign pix_last = c_last && r_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r  <= '0;
            c  <= '0;
            dy <= '0;
            dx <= '0;
        end else begin
            if (tap_step) begin
                if (dx_last) begin
                    dx <= '0;
                    dy <= dy_last ? '0 : dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end
            if (pix_step) begin
                if (c_last) begin
                    c <= '0;
                    r <= r_last ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    logic signed [SW-1:0] ys;
    logic signed [SW-1:0] xs;

    always_comb begin
        ys = $signed(SW'(r)) + $signed(SW'(dy)) - HALF_S;
        xs = $signed(SW'(c)) + $signed(SW'(dx)) - HALF_S;
    end

    assign tap_oob  = ys[SW-1] || (ys >= H_S) || xs[SW-1] || (xs >= W_S);
    assign tap_addr = tap_oob ? '0 : (ys[PIX_AW-1:0] * PIX_AW'(IMG_W) + xs[PIX_AW-1:0]);
    assign tap_idx  = 6'(dy) * 6'(K) + 6'(dx);
    assign pos_addr = PIX_AW'(r) * PIX_AW'(IMG_W) + PIX_AW'(c);

endmodule

// File: rtl/conv_window_sequencer.sv
// Key-driven kernel loader and K*K window address sequencer for image convolution.
// Latency: key accept to first out_we = 2*K*K+2 cycles; memory strobes trail addresses by 1.
// Backpressure: cmd_ready only in IDLE/HOLD (dropped by rst/abort); downstream never stalls.
// Ports: clk, rst (sync, active-high); bus (slave) carries abort, the command
// handshake, kernel ROM address/load strobe, pixel address/tap strobes, MAC
// clear, output write strobe/address, show_orig, busy and done.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int K      = 3,
    parameter int PIX_AW = $clog2(IMG_W*IMG_H),
    parameter int KER_AW = $clog2(3*K*K)
) (
    input logic                   clk,
    input logic                   rst,
    conv_window_sequencer_if.slave bus
);
    state_t            state;
    logic [BANK_W-1:0] bank;
    logic              show_orig_q;

    // Address-issue signals delayed one cycle to line up with memory read data.
    logic              ker_load_q;
    logic [5:0]        ker_idx_q;
    logic              tap_valid_q;
    logic              tap_oob_q;
    logic [5:0]        tap_idx_q;
    logic              mac_clr_q;
    logic              out_we_q;
    logic [PIX_AW-1:0] out_addr_q;
    logic              done_q;

    logic              kill;
    logic              cmd_ready;
    logic              ker_start;

    logic [5:0]        tap_idx;
    logic              tap_last;
    logic              pix_last;
    logic              tap_oob;
    logic [PIX_AW-1:0] tap_addr;
    logic [PIX_AW-1:0] pos_addr;

    assign kill      = rst || bus.abort;
    assign cmd_ready = ((state == ST_IDLE) || (state == ST_HOLD)) && !kill;
    assign ker_start = cmd_ready && bus.cmd_valid && key_is_ker(bus.cmd_key);

    conv_window_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .PIX_AW (PIX_AW)
    ) u_cnt (
        .clk      (clk),
        .rst      (kill),
        .clr      (ker_start),
        .tap_step ((state == ST_LOAD_KER) || (state == ST_CONV)),
        .pix_step ((state == ST_WRITE) && !pix_last),
        .tap_idx  (tap_idx),
        .tap_last (tap_last),
        .pix_last (pix_last),
        .tap_oob  (tap_oob),
        .tap_addr (tap_addr),
        .pos_addr (pos_addr)
    );

    always_ff @(posedge clk) begin
        if (kill) begin
            state       <= ST_IDLE;
            bank        <= '0;
            show_orig_q <= 1'b0;
            ker_load_q  <= 1'b0;
            ker_idx_q   <= '0;
            tap_valid_q <= 1'b0;
            tap_oob_q   <= 1'b0;
            tap_idx_q   <= '0;
            mac_clr_q   <= 1'b0;
            out_we_q    <= 1'b0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            ker_load_q  <= (state == ST_LOAD_KER);
            ker_idx_q   <= (state == ST_LOAD_KER) ? tap_idx : '0;
            tap_valid_q <= (state == ST_CONV);
            tap_oob_q   <= (state == ST_CONV) && tap_oob;
            tap_idx_q   <= (state == ST_CONV) ? tap_idx : '0;
            mac_clr_q   <= (state == ST_CONV) && (tap_idx == 6'd0);
            // The write lands one cycle after WRITE so the MAC has taken the last tap.
            out_we_q    <= (state == ST_WRITE);
            done_q      <= (state == ST_WRITE) && pix_last;
            if (state == ST_WRITE) begin
                out_addr_q <= pos_addr;
            end

            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (bus.cmd_valid) begin
                        if (key_is_orig(bus.cmd_key)) begin
                            show_orig_q <= 1'b1;
                            state       <= ST_HOLD;
                        end else if (key_is_ker(bus.cmd_key)) begin
                            bank        <= key_bank(bus.cmd_key);
                            show_orig_q <= 1'b0;
                            state       <= ST_LOAD_KER;
                        end
                    end
                end
                ST_LOAD_KER: if (tap_last) state <= ST_CONV;
                ST_CONV:     if (tap_last) state <= ST_WRITE;
                ST_WRITE:    state <= pix_last ? ST_HOLD : ST_CONV;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.ker_addr  = (state == ST_LOAD_KER)
                         ? (KER_AW'(bank) * KER_AW'(K*K) + KER_AW'(tap_idx)) : '0;
    assign bus.pix_addr  = (state == ST_CONV) ? tap_addr : '0;
    assign bus.ker_load  = ker_load_q;
    assign bus.ker_idx   = ker_idx_q;
    assign bus.tap_valid = tap_valid_q;
    assign bus.tap_oob   = tap_oob_q;
    assign bus.tap_idx   = tap_idx_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.out_we    = out_we_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.show_orig = show_orig_q;
    assign bus.busy      = (state == ST_LOAD_KER) || (state == ST_CONV) || (state == ST_WRITE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer on a 4x3 frame with a 3x3 kernel.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_conv_window_sequencer;
    localparam int W      = 4;
    localparam int H      = 3;
    localparam int KK     = 3;
    localparam int PIX_AW = 4;
    localparam int KER_AW = 5;
    localparam int TAPS   = KK * KK;
    localparam int NPIX   = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_sequencer_if #(.PIX_AW(PIX_AW), .KER_AW(KER_AW)) bus ();

    conv_window_sequencer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .K      (KK),
        .PIX_AW (PIX_AW),
        .KER_AW (KER_AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt = 0;
    logic [PIX_AW-1:0] prev_pix = '0;
    logic [KER_AW-1:0] prev_ker = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entries: expected cycle plus up to four expected fields.
    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    ev_t ker_q[$];
    ev_t tap_q[$];
    ev_t out_q[$];

    typedef struct {
        logic [7:0] key;
        logic       abort;
        logic       exp_rdy;
        logic       exp_busy;
        logic       exp_show;
        logic       exp_rdy2;
        int         exp_ker_addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic bad(input string name, input int want_cyc);
        n_cmp++;
        n_err++;
        $display("FAIL %s at cycle %0d: event expected at cycle %0d", name, cyc, want_cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.cmd_valid = 1'b0;
        bus.cmd_key   = 8'h00;
        bus.abort     = 1'b0;
    endtask

    // Expected strobes of a full frame whose key is accepted in cycle a.
    task automatic push_frame(input int a, input int bank);
        for (int i = 0; i < TAPS; i++)
            ker_q.push_back('{a + 2 + i, i, bank * TAPS + i, 0, 0});
        for (int p = 0; p < NPIX; p++) begin
            for (int t = 0; t < TAPS; t++) begin
                int y, x, oob, addr;
                y = p / W + t / KK - KK / 2;
                x = p % W + t % KK - KK / 2;
                oob = (y < 0 || y >= H || x < 0 || x >= W) ? 1 : 0;
                addr = oob ? 0 : y * W + x;
                tap_q.push_back('{a + 11 + p * 10 + t, t, oob, addr, (t == 0) ? 1 : 0});
            end
            out_q.push_back('{a + 20 + p * 10, p, (p == NPIX - 1) ? 1 : 0, 0, 0});
        end
    endtask

    // rst/abort in cycle r cancels every strobe expected after r.
    task automatic flush_after(input int r);
        ev_t q2[$];
        q2 = {};
        foreach (ker_q[i]) if (ker_q[i].cyc <= r) q2.push_back(ker_q[i]);
        ker_q = q2;
        q2 = {};
        foreach (tap_q[i]) if (tap_q[i].cyc <= r) q2.push_back(tap_q[i]);
        tap_q = q2;
        q2 = {};
        foreach (out_q[i]) if (out_q[i].cyc <= r) q2.push_back(out_q[i]);
        out_q = q2;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (bus.ker_load) begin
            if (ker_q.size() == 0) bad("unexpected_ker_load", -1);
            else begin
                e = ker_q.pop_front();
                chk("ker_cycle", cyc, e.cyc);
                chk("ker_idx", bus.ker_idx, e.a);
                chk("ker_addr", prev_ker, e.b);
            end
        end
        if (bus.tap_valid) begin
            if (tap_q.size() == 0) bad("unexpected_tap_valid", -1);
            else begin
                e = tap_q.pop_front();
                chk("tap_cycle", cyc, e.cyc);
                chk("tap_idx", bus.tap_idx, e.a);
                chk("tap_oob", bus.tap_oob, e.b);
                chk("tap_pix_addr", prev_pix, e.c);
                chk("tap_mac_clr", bus.mac_clr, e.d);
            end
        end else if (bus.mac_clr || bus.tap_oob) begin
            bad("stray_tap_flag", -1);
        end
        if (bus.out_we) begin
            if (out_q.size() == 0) bad("unexpected_out_we", -1);
            else begin
                e = out_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("out_addr", bus.out_addr, e.a);
                chk("out_done", bus.done, e.b);
            end
        end else if (bus.done) begin
            bad("done_without_out_we", -1);
        end
        while (ker_q.size() > 0 && ker_q[0].cyc < cyc) begin
            e = ker_q.pop_front();
            bad("missing_ker_load", e.cyc);
        end
        while (tap_q.size() > 0 && tap_q[0].cyc < cyc) begin
            e = tap_q.pop_front();
            bad("missing_tap_valid", e.cyc);
        end
        while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
            e = out_q.pop_front();
            bad("missing_out_we", e.cyc);
        end
        if (bus.busy) busy_cnt++;
        prev_pix = bus.pix_addr;
        prev_ker = bus.ker_addr;
    end

    initial begin : watchdog
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: run did not complete, got timeout, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        vec_t vecs[8];
        int a;
        vecs[0] = '{8'h16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h1E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h26, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{8'h1D, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9};
        vecs[5] = '{8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18};
        vecs[6] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};

        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_show_orig", bus.show_orig, 0);
        chk("rst_strobes", {bus.ker_load, bus.tap_valid, bus.mac_clr, bus.out_we, bus.done}, 0);
        chk("rst_addrs", {bus.ker_addr, bus.pix_addr, bus.out_addr}, 0);

        // Single-command decode from IDLE, each row then aborted back to IDLE.
        for (int i = 0; i < 8; i++) begin
            step();
            a = cyc;
            bus.cmd_valid = 1'b1;
            bus.cmd_key   = vecs[i].key;
            bus.abort     = vecs[i].abort;
            if (vecs[i].exp_busy) push_frame(a, vecs[i].exp_ker_addr / TAPS);
            @(negedge clk);
            chk($sformatf("vec%0d_cmd_ready", i), bus.cmd_ready, vecs[i].exp_rdy);
            step();
            idle_in();
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_show_orig", i), bus.show_orig, vecs[i].exp_show);
            chk($sformatf("vec%0d_cmd_ready_next", i), bus.cmd_ready, vecs[i].exp_rdy2);
            chk($sformatf("vec%0d_ker_addr", i), bus.ker_addr, vecs[i].exp_ker_addr);
            step();
            bus.abort = 1'b1;
            flush_after(cyc);
            step();
            bus.abort = 1'b0;
        end

        // Full frame with bank 0, plus a key poked while busy.
        step();
        a = cyc;
        busy_cnt = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 8'h15;
        push_frame(a, 0);
        step();
        idle_in();
        while (cyc < a + 30) step();
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 8'h16;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_cmd_ready", bus.cmd_ready, 0);
            step();
        end
        idle_in();
        for (int k = 0; k < 300 && out_q.size() > 0; k++) step();
        @(negedge clk);
        chk("frame_drained", out_q.size(), 0);
        chk("frame_busy_cycles", busy_cnt, 9 + 12 * 10);
        chk("hold_cmd_ready", bus.cmd_ready, 1);
        chk("hold_busy", bus.busy, 0);
        chk("hold_show_orig", bus.show_orig, 0);

        // Original-image key in HOLD.
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 8'h16;
        @(negedge clk);
        chk("hold_key_ready", bus.cmd_ready, 1);
        step();
        idle_in();
        @(negedge clk);
        chk("hold_key_show_orig", bus.show_orig, 1);
        chk("hold_key_busy", bus.busy, 0);

        // Abort together with a kernel key in HOLD: refused, back to IDLE.
        step();
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 8'h15;
        bus.abort     = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", bus.cmd_ready, 0);
        step();
        idle_in();
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_show_orig", bus.show_orig, 0);
        chk("abort_idle_ready", bus.cmd_ready, 1);
        repeat (5) step();

        // Reset 20 cycles into a bank-1 frame.
        step();
        a = cyc;
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 8'h1D;
        push_frame(a, 1);
        step();
        idle_in();
        while (cyc < a + 20) step();
        rst = 1'b1;
        flush_after(cyc);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_strobes", {bus.ker_load, bus.tap_valid, bus.mac_clr, bus.out_we, bus.done}, 0);
        chk("midrst_show_orig", bus.show_orig, 0);
        repeat (40) step();

        @(negedge clk);
        chk("ker_q_empty", ker_q.size(), 0);
        chk("tap_q_empty", tap_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
